// File: rtl/pulse_trigger.sv
// pulse_trigger: qualifies a hydrophone pulse as a run of consecutive
// above-threshold samples, fires a one-cycle trigger, marks a fixed-length
// post-trigger capture window, then waits for release and an optional holdoff.
module pulse_trigger #(
    parameter int unsigned DATA_W             = 16,
    parameter int unsigned THRESHOLD          = 32,
    parameter int unsigned VALID_COUNT_NEEDED = 20,
    parameter int unsigned NUM_READINGS       = 500,
    parameter int unsigned HOLDOFF_CYCLES     = 1024,
    parameter int unsigned CNT_W              = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic              arm_i,
    input  logic              release_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    output logic              capture_o,
    output logic              trigger_o,
    output logic              done_o,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  run_count_o,
    output logic [CNT_W-1:0]  captured_count_o
);

    localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(VALID_COUNT_NEEDED);
    localparam logic [CNT_W-1:0] CAP_TARGET = CNT_W'(NUM_READINGS);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        QUALIFY      = 3'd1,
        CAPTURE      = 3'd2,
        WAIT_RELEASE = 3'd3,
        HOLDOFF      = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   run_count, run_n;
    logic [CNT_W-1:0]   cap_count, cap_n;
    logic [CNT_W-1:0]   hold_count, hold_n;
    logic               trigger_n, capture_n;
    logic [DATA_W-1:0]  neg_full;
    logic [DATA_W-2:0]  mag;
    logic               hit;

    // Saturating magnitude of the incoming sample and threshold hit detect
    always_comb begin
        neg_full = ~sample_i + DATA_W'(1);
        if (!sample_i[DATA_W-1]) begin
            mag = sample_i[DATA_W-2:0];
        end else if (neg_full[DATA_W-1]) begin
            mag = '1;
        end else begin
            mag = neg_full[DATA_W-2:0];
        end
        hit = sample_valid_i && (32'(mag) >= THRESHOLD);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        run_n     = run_count;
        cap_n     = cap_count;
        hold_n    = hold_count;
        trigger_n = 1'b0;
        capture_n = 1'b0;
        case (state)
            IDLE: begin
                run_n = '0;
                if (arm_i) state_n = QUALIFY;
            end
            QUALIFY: begin
                if (!arm_i) begin
                    state_n = IDLE;
                    run_n   = '0;
                end else if (sample_valid_i) begin
                    if (!hit) begin
                        run_n = '0;
                    end else if (run_count + CNT_W'(1) == RUN_TARGET) begin
                        state_n   = CAPTURE;
                        trigger_n = 1'b1;
                        run_n     = '0;
                        cap_n     = '0;
                    end else begin
                        run_n = run_count + CNT_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid_i) begin
                    capture_n = 1'b1;
                    cap_n     = cap_count + CNT_W'(1);
                    if (cap_count + CNT_W'(1) == CAP_TARGET) state_n = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (release_i) begin
                    if (HOLD_LOAD == '0) begin
                        state_n = arm_i ? QUALIFY : IDLE;
                    end else begin
                        state_n = HOLDOFF;
                        hold_n  = HOLD_LOAD;
                    end
                end
            end
            HOLDOFF: begin
                run_n = '0;
                if (hold_count <= CNT_W'(1)) begin
                    hold_n  = '0;
                    state_n = arm_i ? QUALIFY : IDLE;
                end else begin
                    hold_n = hold_count - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                run_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            run_count      <= '0;
            cap_count      <= '0;
            hold_count     <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            capture_o      <= 1'b0;
            trigger_o      <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state          <= state_n;
            run_count      <= run_n;
            cap_count      <= cap_n;
            hold_count     <= hold_n;
            sample_o       <= sample_i;
            sample_valid_o <= sample_valid_i;
            capture_o      <= capture_n;
            trigger_o      <= trigger_n;
            done_o         <= (state_n == WAIT_RELEASE);
        end
    end

    assign state_o          = state;
    assign run_count_o      = run_count;
    assign captured_count_o = cap_count;

endmodule

// File: tb/tb_pulse_trigger.sv
// Self-checking bench for pulse_trigger with default parameters.
module tb_pulse_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample;
    logic        sample_valid;
    logic        arm;
    logic        rel_p;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic        capture_o;
    logic        trigger_o;
    logic        done_o;
    logic [2:0]  state_o;
    logic [15:0] run_count_o;
    logic [15:0] captured_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        v;
        logic        c;
        logic        d;
    } exp_t;

    exp_t sb[$];

    pulse_trigger dut (
        .clk              (clk),
        .rst              (rst),
        .sample_i         (sample),
        .sample_valid_i   (sample_valid),
        .arm_i            (arm),
        .release_i        (rel_p),
        .sample_o         (sample_o),
        .sample_valid_o   (sample_valid_o),
        .capture_o        (capture_o),
        .trigger_o        (trigger_o),
        .done_o           (done_o),
        .state_o          (state_o),
        .run_count_o      (run_count_o),
        .captured_count_o (captured_count_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input; outputs are valid on return
    task automatic step(input logic [15:0] s, input logic v);
        sample       = s;
        sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic arm_and_trigger();
        do_reset();
        arm = 1'b1;
        idle(1);
        repeat (20) step(16'd40, 1'b1);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(16'h1234, 1'b1);
            n_cmp++;
            if ({sample_o, sample_valid_o, capture_o, trigger_o, done_o, state_o,
                 run_count_o, captured_count_o} !== '0) begin
                n_bad++;
                $display("FAIL reset_zero[%0d]: got so=%h sv=%b cap=%b trg=%b done=%b st=%0d run=%0d cc=%0d, need all 0",
                         i, sample_o, sample_valid_o, capture_o, trigger_o, done_o, state_o,
                         run_count_o, captured_count_o);
            end
        end
        rst = 1'b0;
        arm = 1'b0;
        sb.push_back('{s: 16'h1234, v: 1'b1, c: 1'b0, d: 1'b0});
        step(16'h1234, 1'b1);
        e = sb.pop_front();
        n_cmp++;
        if ({sample_o, sample_valid_o, capture_o, done_o} !== e) begin
            n_bad++;
            $display("FAIL passthrough: got so=%h sv=%b cap=%b done=%b, need so=%h sv=%b cap=%b done=%b",
                     sample_o, sample_valid_o, capture_o, done_o, e.s, e.v, e.c, e.d);
        end
        step(16'h0000, 1'b0);
        n_cmp++;
        if (sample_valid_o !== 1'b0 || state_o !== 3'd0) begin
            n_bad++;
            $display("FAIL passthrough_idle: got sv=%b st=%0d, need sv=0 st=0", sample_valid_o, state_o);
        end
    endtask

    task automatic test_trigger_exact();
        do_reset();
        arm = 1'b1;
        idle(1);
        n_cmp++;
        if (state_o !== 3'd1) begin
            n_bad++;
            $display("FAIL arm_to_qualify: got st=%0d, need 1", state_o);
        end
        for (int k = 1; k <= 20; k++) begin
            step(16'd40, 1'b1);
            n_cmp++;
            if (trigger_o !== (k == 20) || run_count_o !== ((k == 20) ? 16'd0 : 16'(k))) begin
                n_bad++;
                $display("FAIL trig_run[%0d]: got trg=%b run=%0d, need trg=%b run=%0d",
                         k, trigger_o, run_count_o, (k == 20), (k == 20) ? 0 : k);
            end
        end
        n_cmp++;
        if (state_o !== 3'd2 || capture_o !== 1'b0) begin
            n_bad++;
            $display("FAIL trig_state: got st=%0d cap=%b, need st=2 cap=0", state_o, capture_o);
        end
        step(16'h0000, 1'b0);
        n_cmp++;
        if (trigger_o !== 1'b0) begin
            n_bad++;
            $display("FAIL trig_one_cycle: got trg=%b, need 0", trigger_o);
        end
        do_reset();
        arm = 1'b1;
        idle(1);
        repeat (19) step(16'd40, 1'b1);
        step(16'd10, 1'b1);
        n_cmp++;
        if (run_count_o !== 16'd0 || trigger_o !== 1'b0 || state_o !== 3'd1) begin
            n_bad++;
            $display("FAIL miss_clears: got run=%0d trg=%b st=%0d, need run=0 trg=0 st=1",
                     run_count_o, trigger_o, state_o);
        end
    endtask

    task automatic test_negative();
        int early;
        do_reset();
        arm = 1'b1;
        idle(1);
        early = 0;
        for (int k = 1; k <= 20; k++) begin
            step((k % 2 == 1) ? 16'hFFD8 : 16'h8000, 1'b1);
            if (k < 20 && trigger_o !== 1'b0) early++;
        end
        n_cmp++;
        if (trigger_o !== 1'b1 || early != 0) begin
            n_bad++;
            $display("FAIL neg_sat_trigger: got trg=%b early=%0d, need trg=1 early=0", trigger_o, early);
        end
        do_reset();
        arm = 1'b1;
        idle(1);
        early = 0;
        repeat (20) begin
            step(16'hFFE1, 1'b1);
            if (trigger_o !== 1'b0 || run_count_o !== 16'd0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL below_threshold: got %0d cycles with trigger/run activity, need 0", early);
        end
        do_reset();
        arm = 1'b1;
        idle(1);
        early = 0;
        for (int k = 1; k <= 20; k++) begin
            step(16'd32, 1'b1);
            if (k < 20 && trigger_o !== 1'b0) early++;
        end
        n_cmp++;
        if (trigger_o !== 1'b1 || early != 0 || state_o !== 3'd2) begin
            n_bad++;
            $display("FAIL threshold_inclusive: got trg=%b early=%0d st=%0d, need trg=1 early=0 st=2",
                     trigger_o, early, state_o);
        end
    endtask

    // Triggers, then streams 501 samples and scoreboards each output cycle
    task automatic test_window(input logic gaps, input logic arm_during);
        exp_t e;
        int   captured;
        int   cap_seen;
        int   bad;
        logic [15:0] s;
        arm_and_trigger();
        arm      = arm_during;
        captured = 0;
        cap_seen = 0;
        bad      = 0;
        for (int idx = 0; idx < 501; idx++) begin
            int g;
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int j = 0; j < g; j++) begin
                sb.push_back('{s: 16'h0000, v: 1'b0, c: 1'b0, d: (captured >= 500)});
                step(16'h0000, 1'b0);
                e = sb.pop_front();
                if (capture_o === 1'b1) cap_seen++;
                if ({sample_o, sample_valid_o, capture_o, done_o} !== e) begin
                    bad++;
                    if (bad <= 4)
                        $display("FAIL window_gap[%0d]: got so=%h sv=%b cap=%b done=%b, need so=%h sv=%b cap=%b done=%b",
                                 idx, sample_o, sample_valid_o, capture_o, done_o, e.s, e.v, e.c, e.d);
                end
            end
            s = 16'($urandom);
            if (captured < 500) captured++;
            sb.push_back('{s: s, v: 1'b1, c: (idx < 500), d: (captured >= 500)});
            step(s, 1'b1);
            e = sb.pop_front();
            if (capture_o === 1'b1) cap_seen++;
            if ({sample_o, sample_valid_o, capture_o, done_o} !== e) begin
                bad++;
                if (bad <= 4)
                    $display("FAIL window_sample[%0d]: got so=%h sv=%b cap=%b done=%b, need so=%h sv=%b cap=%b done=%b",
                             idx, sample_o, sample_valid_o, capture_o, done_o, e.s, e.v, e.c, e.d);
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL window_scoreboard: got %0d mismatching cycles, need 0", bad);
        end
        n_cmp++;
        if (cap_seen != 500) begin
            n_bad++;
            $display("FAIL window_pulses: got %0d capture pulses, need 500", cap_seen);
        end
        n_cmp++;
        if (state_o !== 3'd3 || done_o !== 1'b1 || captured_count_o !== 16'd500) begin
            n_bad++;
            $display("FAIL window_end: got st=%0d done=%b cc=%0d, need st=3 done=1 cc=500",
                     state_o, done_o, captured_count_o);
        end
    endtask

    // Expects WAIT_RELEASE on entry
    task automatic test_holdoff(input logic arm_v);
        int bad;
        arm   = arm_v;
        rel_p = 1'b1;
        step(16'h0000, 1'b0);
        rel_p = 1'b0;
        n_cmp++;
        if (state_o !== 3'd4 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL release_enter: got st=%0d done=%b, need st=4 done=0", state_o, done_o);
        end
        bad = 0;
        for (int i = 1; i <= 1023; i++) begin
            step(16'd40, 1'b1);
            if (state_o !== 3'd4 || trigger_o !== 1'b0 || run_count_o !== 16'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL holdoff_hold: got %0d bad cycles in holdoff, need 0", bad);
        end
        step(16'd40, 1'b1);
        n_cmp++;
        if (state_o !== (arm_v ? 3'd1 : 3'd0) || run_count_o !== 16'd0) begin
            n_bad++;
            $display("FAIL holdoff_exit: got st=%0d run=%0d, need st=%0d run=0",
                     state_o, run_count_o, arm_v ? 1 : 0);
        end
    endtask

    task automatic test_release_in_qualify();
        do_reset();
        arm = 1'b1;
        idle(1);
        repeat (5) step(16'd40, 1'b1);
        rel_p = 1'b1;
        step(16'h0000, 1'b0);
        rel_p = 1'b0;
        n_cmp++;
        if (state_o !== 3'd1 || run_count_o !== 16'd5 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL release_ignored: got st=%0d run=%0d done=%b, need st=1 run=5 done=0",
                     state_o, run_count_o, done_o);
        end
        repeat (15) step(16'd40, 1'b1);
        n_cmp++;
        if (trigger_o !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ignored_trig: got trg=%b, need 1", trigger_o);
        end
    endtask

    task automatic test_abort();
        int bad;
        do_reset();
        arm = 1'b1;
        idle(1);
        repeat (10) step(16'd40, 1'b1);
        n_cmp++;
        if (run_count_o !== 16'd10) begin
            n_bad++;
            $display("FAIL abort_run10: got run=%0d, need 10", run_count_o);
        end
        arm = 1'b0;
        step(16'd40, 1'b1);
        n_cmp++;
        if (state_o !== 3'd0 || run_count_o !== 16'd0 || trigger_o !== 1'b0) begin
            n_bad++;
            $display("FAIL disarm_priority: got st=%0d run=%0d trg=%b, need st=0 run=0 trg=0",
                     state_o, run_count_o, trigger_o);
        end
        arm_and_trigger();
        repeat (250) step(16'($urandom), 1'b1);
        n_cmp++;
        if (captured_count_o !== 16'd250 || state_o !== 3'd2) begin
            n_bad++;
            $display("FAIL mid_window: got cc=%0d st=%0d, need cc=250 st=2", captured_count_o, state_o);
        end
        rst = 1'b1;
        step(16'd40, 1'b1);
        rst = 1'b0;
        arm = 1'b0;
        n_cmp++;
        if ({sample_o, sample_valid_o, capture_o, trigger_o, done_o, state_o,
             run_count_o, captured_count_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_abort: got so=%h sv=%b cap=%b trg=%b done=%b st=%0d run=%0d cc=%0d, need all 0",
                     sample_o, sample_valid_o, capture_o, trigger_o, done_o, state_o,
                     run_count_o, captured_count_o);
        end
        bad = 0;
        repeat (3) begin
            step(16'd40, 1'b1);
            if (done_o !== 1'b0 || trigger_o !== 1'b0 || capture_o !== 1'b0 || state_o !== 3'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL reset_abort_after: got %0d cycles with activity, need 0", bad);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        arm          = 1'b0;
        rel_p        = 1'b0;
        test_reset();
        test_trigger_exact();
        test_negative();
        test_window(1'b1, 1'b1);
        test_holdoff(1'b1);
        test_window(1'b0, 1'b0);
        test_holdoff(1'b0);
        test_release_in_qualify();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
